// File: rtl/abz_quad_decoder.sv
// ABZ quadrature decoder: 2-flop sync, per-channel glitch filter, x4 decode, Z index capture.
// Optional build macro ABZ_Z_CLEAR_EN: a Z index event also zeroes the position count.
module abz_quad_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cnt_clr,
  input  logic        data_a_in,
  input  logic        data_b_in,
  input  logic        data_z_in,
  output logic [31:0] cnt_out,
  output logic        cnt_valid,
  output logic        dir,
  output logic [31:0] z_pos,
  output logic        z_seen,
  output logic        err_flag
);

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [4:0] SETTLE   = 5'(FILT_LEN + 3);

`ifdef ABZ_Z_CLEAR_EN
  localparam bit Z_CLEAR = 1'b1;
`else
  localparam bit Z_CLEAR = 1'b0;
`endif

  // channel order in the vectors below: [0]=A, [1]=B, [2]=Z
  logic [2:0] sync1, sync2, filt;
  logic [3:0] fcnt [3];
  logic [1:0] prev_ab;
  logic       prev_z;
  logic [4:0] settle_cnt;

  logic [1:0]  cur_ab;
  logic        armed, active, fwd, rev, illegal, z_event;
  logic [31:0] cnt_next, z_pos_next;
  logic        dir_next, z_seen_next, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {data_z_in, data_b_in, data_a_in};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  // After reset the filters need FILT_LEN+2 cycles to reach the real pin levels;
  // decoding is held off until then so that climb is never seen as motion.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= SETTLE;
      prev_ab    <= '0;
      prev_z     <= 1'b0;
    end else begin
      if (settle_cnt != 5'd0) settle_cnt <= settle_cnt - 5'd1;
      prev_ab <= cur_ab;
      prev_z  <= filt[2];
    end
  end

  always_comb begin
    cur_ab  = {filt[0], filt[1]};
    armed   = (settle_cnt == 5'd0);
    active  = armed && enable;
    fwd     = 1'b0;
    rev     = 1'b0;
    case ({prev_ab, cur_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = active;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = active;
      default: ;
    endcase
    illegal = active && ((prev_ab ^ cur_ab) == 2'b11);
    z_event = active && filt[2] && !prev_z;
  end

  always_comb begin
    cnt_next    = cnt_out;
    dir_next    = dir;
    z_pos_next  = z_pos;
    z_seen_next = z_seen;
    err_next    = err_flag;
    if (z_event && !cnt_clr) begin
      z_pos_next  = cnt_out;
      z_seen_next = 1'b1;
    end
    if (cnt_clr) begin
      cnt_next    = '0;
      z_seen_next = 1'b0;
      err_next    = 1'b0;
    end else if (z_event && Z_CLEAR) begin
      cnt_next = '0;
    end else if (fwd) begin
      cnt_next = cnt_out + 32'd1;
      dir_next = 1'b1;
    end else if (rev) begin
      cnt_next = cnt_out - 32'd1;
      dir_next = 1'b0;
    end
    // a fresh illegal transition outranks a concurrent clear
    if (illegal) err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      dir       <= 1'b1;
      z_pos     <= '0;
      z_seen    <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      cnt_out   <= cnt_next;
      cnt_valid <= (cnt_next != cnt_out);
      dir       <= dir_next;
      z_pos     <= z_pos_next;
      z_seen    <= z_seen_next;
      err_flag  <= err_next;
    end
  end

endmodule

// File: doc/abz_quad_decoder.md
ABZ_QUAD_DECODER -- requirements
Module: abz_quad_decoder

Interface
REQ-001 The block SHALL have parameter FILT_LEN, default 4, meaning consecutive stable clk samples required before a filtered A/B/Z level changes (legal 1..15).
REQ-002 The block SHALL have port clk  input  1  100MHz system clock; one clock domain, all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port enable  input  1  count enable, driven from the encoder mode decode (ABZ mode selected).
REQ-005 The block SHALL have port cnt_clr  input  1  single-cycle pulse: clear position, z_seen and err_flag.
REQ-006 The block SHALL have port data_a_in / data_b_in / data_z_in  input  1 each  raw asynchronous encoder A, B, Z pins.
REQ-007 The block SHALL have port cnt_out  output  32  signed position count, consumed by the encoder data register feeding the EMIF write path.
REQ-008 The block SHALL have port cnt_valid  output  1  one-cycle pulse whenever cnt_out changes value.
REQ-009 The block SHALL have port dir  output  1  last step direction, 1 = forward.
REQ-010 The block SHALL have port z_pos  output  32  cnt_out value captured at the last Z index edge.
REQ-011 The block SHALL have port z_seen  output  1  sticky, set on first Z index edge.
REQ-012 The block SHALL have port err_flag  output  1  sticky, illegal quadrature transition detected.

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Each synchronized input SHALL feed a filter: a per-channel counter that resets whenever the synced value equals the filtered value, and the filtered value takes the synced value after FILT_LEN consecutive differing samples.
REQ-015 Latency from a pin edge held stable to the cnt_out update SHALL be exactly FILT_LEN+3 clk cycles; pulses shorter than FILT_LEN cycles SHALL be rejected.
REQ-016 Decode SHALL compare filtered {A,B} with its previous-cycle value: 00->10->11->01->00 = +1 (dir=1); reverse sequence = -1 (dir=0); no change = no action.
REQ-017 A transition with both A and B changing in one cycle SHALL set err_flag, leave cnt_out and dir unchanged and generate no cnt_valid.
REQ-018 Arithmetic SHALL be 32-bit two's-complement modulo: 0x7FFFFFFF+1 = 0x80000000, 0x00000000-1 = 0xFFFFFFFF, no saturation.
REQ-019 A Z index event SHALL be a rising edge of filtered Z while enable=1; on it z_pos SHALL capture the pre-update cnt_out and z_seen SHALL set.
REQ-020 With enable=0 the previous-{A,B} register SHALL keep tracking, cnt_out/z_pos/dir SHALL hold, and no step SHALL be counted on re-enable from the held state.
REQ-021 Priority in one cycle SHALL be: cnt_clr > Z-clear (see REQ-026) > step; err_flag set by a new illegal transition SHALL win over cnt_clr.
REQ-022 cnt_valid SHALL pulse for one cycle on any step, clear, or Z-clear that changes cnt_out, and SHALL stay low when the value is unchanged (e.g. cnt_clr at count 0).

Reset
REQ-023 On rst=1 at a clk edge: cnt_out=0, z_pos=0, cnt_valid=0, dir=1, z_seen=0, err_flag=0, filter counters=0.
REQ-024 On reset, synchronizers, filtered values and previous-{A,B} SHALL load 0; the first cycle after reset SHALL not count a step from the 00 reset state if pins are not at 00 (previous-{A,B} loads the filtered value on the first post-reset cycle).
REQ-025 Reset asserted mid-filter or mid-step SHALL discard the pending event entirely.

Configuration
REQ-026 With macro ABZ_Z_CLEAR_EN defined, a Z index event SHALL additionally load cnt_out=0 in the same cycle as the z_pos capture, discarding any concurrent step; without it, Z only captures z_pos and sets z_seen, and counting is unaffected.

Verification
REQ-027 FILT_LEN=4, enable=1, drive 8 forward quadrature cycles (32 edges, 20 clk apart) -> cnt_out=32, dir=1, 32 cnt_valid pulses, first update 7 clk after first pin edge.
REQ-028 From cnt_out=0 drive one reverse edge -> cnt_out=0xFFFFFFFF, dir=0; then one forward edge -> cnt_out=0.
REQ-029 Glitch of 3 clk on data_a_in (FILT_LEN=4) -> cnt_out unchanged, no cnt_valid; glitch of 4 clk -> counted.
REQ-030 Toggle A and B on the same clk edge from 00 to 11 -> err_flag=1, cnt_out unchanged; cnt_clr in that same cycle -> err_flag still 1.
REQ-031 At cnt_out=100 raise Z -> z_pos=100, z_seen=1; with ABZ_Z_CLEAR_EN cnt_out=0 and one cnt_valid, without it cnt_out stays 100.
REQ-032 Assert rst for 1 cycle mid-sequence at cnt_out=57 with pins at 11 -> all outputs at reset values, then next forward edge 11->01 counts cnt_out=1 with no spurious step.
